// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: locks onto h_sync/v_sync, rebuilds pixel
// coordinates and data-enable, and pulses h_err/v_err on sync timing faults.
module vga_sync_decoder #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_SYNC_START = 656,
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_SYNC_START = 490,
  parameter int unsigned V_TOTAL      = 525,
  parameter logic        SYNC_POL     = 1'b0,
  parameter int unsigned H_LOCK_LINES = 2
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic       red,
  input  logic       green,
  input  logic       blue,
  output logic [9:0] x_count,
  output logic [9:0] y_count,
  output logic       de,
  output logic       red_o,
  output logic       green_o,
  output logic       blue_o,
  output logic       locked,
  output logic       frame_start,
  output logic       h_err,
  output logic       v_err
);

  localparam int unsigned XW = 10;
  localparam int unsigned YW = 10;
  localparam int unsigned CW = 8;

  localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_SYNC = XW'(H_SYNC_START);
  localparam logic [XW-1:0] X_ACT  = XW'(H_ACTIVE);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_SYNC = YW'(V_SYNC_START);
  localparam logic [YW-1:0] Y_ACT  = YW'(V_ACTIVE);
  localparam logic [CW-1:0] C_LOCK = CW'(H_LOCK_LINES);

  typedef enum logic [1:0] {ACQ_H, ACQ_V, LOCKED} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic          h_seen_q, h_seen_d;
  logic          v_seen_q, v_seen_d;
  logic          h_prev_q, v_prev_q;
  logic [XW-1:0] x_q, x_d, px;
  logic [YW-1:0] y_q, y_d, py;
  logic          h_edge, v_edge, h_match, v_match, h_miss, v_miss;
  logic          h_err_q, h_err_d, v_err_q, v_err_d;
  logic          locked_q, locked_d, de_q, de_d, fs_q, fs_d;
  logic          r_q, r_d, g_q, g_d, b_q, b_d;

  // Coordinate prediction and sync-edge alignment
  always_comb begin
    px      = (x_q == X_LAST) ? '0 : x_q + XW'(1);
    py      = y_q;
    if (x_q == X_LAST) py = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
    h_edge  = (h_sync == SYNC_POL) && (h_prev_q != SYNC_POL);
    v_edge  = (v_sync == SYNC_POL) && (v_prev_q != SYNC_POL);
    h_match = (px == X_SYNC);
    v_match = (py == Y_SYNC);
    h_miss  = h_match && !h_edge;
    // Missing v-sync is judged only on the first line predicted to carry it
    v_miss  = v_match && (y_q != Y_SYNC) && !v_edge;
    x_d     = h_edge ? X_SYNC : px;
    y_d     = v_edge ? Y_SYNC : py;
  end

  // Next-state logic for the acquisition FSM
  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    h_seen_d = h_seen_q;
    v_seen_d = v_seen_q;
    h_err_d  = 1'b0;
    v_err_d  = 1'b0;
    unique case (state_q)
      ACQ_H: begin
        if (h_edge) begin
          if (!h_seen_q) begin
            h_seen_d = 1'b1;
          end else if (h_match) begin
            if (hcnt_q + CW'(1) >= C_LOCK) begin
              state_d  = ACQ_V;
              hcnt_d   = '0;
              v_seen_d = 1'b0;
            end else begin
              hcnt_d = hcnt_q + CW'(1);
            end
          end else begin
            hcnt_d = '0;
          end
        end
      end
      ACQ_V: begin
        if (h_edge && !h_match) begin
          state_d  = ACQ_H;
          hcnt_d   = '0;
          h_seen_d = 1'b0;
        end else if (v_edge) begin
          if (!v_seen_q) v_seen_d = 1'b1;
          else if (v_match) state_d = LOCKED;
        end
      end
      LOCKED: begin
        h_err_d = (h_edge && !h_match) || h_miss;
        v_err_d = (v_edge && !v_match) || v_miss;
        if (h_err_d || v_err_d) begin
          state_d  = ACQ_H;
          hcnt_d   = '0;
          h_seen_d = 1'b0;
        end
      end
      default: state_d = ACQ_H;
    endcase
  end

  // Output next values, derived from the next state and coordinates
  always_comb begin
    locked_d = (state_d == LOCKED);
    de_d     = locked_d && (x_d < X_ACT) && (y_d < Y_ACT);
    fs_d     = locked_d && (x_d == '0) && (y_d == '0);
    r_d      = red   & de_d;
    g_d      = green & de_d;
    b_d      = blue  & de_d;
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q  <= ACQ_H;
      hcnt_q   <= '0;
      h_seen_q <= 1'b0;
      v_seen_q <= 1'b0;
      h_prev_q <= ~SYNC_POL;
      v_prev_q <= ~SYNC_POL;
      x_q      <= '0;
      y_q      <= '0;
      h_err_q  <= 1'b0;
      v_err_q  <= 1'b0;
      locked_q <= 1'b0;
      de_q     <= 1'b0;
      fs_q     <= 1'b0;
      r_q      <= 1'b0;
      g_q      <= 1'b0;
      b_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      h_seen_q <= h_seen_d;
      v_seen_q <= v_seen_d;
      h_prev_q <= h_sync;
      v_prev_q <= v_sync;
      x_q      <= x_d;
      y_q      <= y_d;
      h_err_q  <= h_err_d;
      v_err_q  <= v_err_d;
      locked_q <= locked_d;
      de_q     <= de_d;
      fs_q     <= fs_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
    end
  end

  assign x_count     = x_q;
  assign y_count     = y_q;
  assign de          = de_q;
  assign red_o       = r_q;
  assign green_o     = g_q;
  assign blue_o      = b_q;
  assign locked      = locked_q;
  assign frame_start = fs_q;
  assign h_err       = h_err_q;
  assign v_err       = v_err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder on a scaled-down 32x20 raster with
// directed lock, h-glitch, missing-vsync and mid-frame reset events.
module tb_vga_sync_decoder;

  localparam int HA  = 16;
  localparam int HS  = 20;
  localparam int HSW = 4;
  localparam int HT  = 32;
  localparam int VA  = 12;
  localparam int VS  = 14;
  localparam int VSW = 2;
  localparam int VT  = 20;
  localparam logic POL = 1'b0;

  logic       Clk = 1'b0;
  logic       reset = 1'b0;
  logic       h_sync = 1'b1, v_sync = 1'b1;
  logic       red = 1'b0, green = 1'b0, blue = 1'b0;
  logic [9:0] x_count, y_count;
  logic       de, red_o, green_o, blue_o, locked, frame_start, h_err, v_err;

  always #5 Clk = ~Clk;

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_SYNC_START(HS), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC_START(VS), .V_TOTAL(VT),
    .SYNC_POL(POL), .H_LOCK_LINES(2)
  ) dut (
    .Clk(Clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync),
    .red(red), .green(green), .blue(blue),
    .x_count(x_count), .y_count(y_count), .de(de),
    .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
    .locked(locked), .frame_start(frame_start), .h_err(h_err), .v_err(v_err)
  );

  typedef struct {
    bit         xy;
    logic [9:0] x, y;
    logic       de, r, g, b, lk, fs, he, ve;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   gx, gy, fr;
  bit   exp_lk;

  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic bit at(input int f, input int x, input int y);
    return (fr == f) && (gx == x) && (gy == y);
  endfunction

  // Drive one generator sample and push the hand-derived response for it
  task automatic apply(input bit rst);
    exp_t e;
    bit   glitch, sup, he, ve, dd;
    glitch = (fr == 3) && (gy == 2);
    sup    = (fr == 5) && (gy >= VS) && (gy < VS + VSW);
    if (glitch) h_sync = (gx >= HS + 3 && gx < HS + 3 + HSW) ? POL : ~POL;
    else        h_sync = (gx >= HS && gx < HS + HSW) ? POL : ~POL;
    v_sync = (!sup && gy >= VS && gy < VS + VSW) ? POL : ~POL;
    red    = 1'b1;
    green  = gx[0];
    blue   = gy[0] ^ gx[1];
    reset  = ~rst;
    he = !rst && at(3, HS, 2);
    ve = !rst && at(5, 0, VS);
    if (rst || he || ve) exp_lk = 1'b0;
    if (!rst && (at(1, 0, VS) || at(4, 0, VS) || at(7, 0, VS) || at(9, 0, VS)))
      exp_lk = 1'b1;
    if (rst) begin
      e = '{xy: 1'b1, x: 10'd0, y: 10'd0, de: 1'b0, r: 1'b0, g: 1'b0, b: 1'b0,
            lk: 1'b0, fs: 1'b0, he: 1'b0, ve: 1'b0};
    end else begin
      dd   = exp_lk && (gx < HA) && (gy < VA);
      e.xy = exp_lk;
      e.x  = 10'(gx);
      e.y  = 10'(gy);
      e.de = dd;
      e.r  = red & dd;
      e.g  = green & dd;
      e.b  = blue & dd;
      e.lk = exp_lk;
      e.fs = exp_lk && (gx == 0) && (gy == 0);
      e.he = he;
      e.ve = ve;
    end
    q.push_back(e);
  endtask

  task automatic advance();
    gx++;
    if (gx == HT) begin
      gx = 0;
      gy++;
      if (gy == VT) begin
        gy = 0;
        fr++;
      end
    end
  endtask

  // Monitor: one response per sampled vector, compared just after the edge
  always begin
    exp_t e;
    @(posedge Clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("locked", 10'(locked), 10'(e.lk));
      chk("de", 10'(de), 10'(e.de));
      chk("red_o", 10'(red_o), 10'(e.r));
      chk("green_o", 10'(green_o), 10'(e.g));
      chk("blue_o", 10'(blue_o), 10'(e.b));
      chk("frame_start", 10'(frame_start), 10'(e.fs));
      chk("h_err", 10'(h_err), 10'(e.he));
      chk("v_err", 10'(v_err), 10'(e.ve));
      if (e.xy) begin
        chk("x_count", x_count, e.x);
        chk("y_count", y_count, e.y);
      end
    end
  end

  initial begin
    gx = 5;
    gy = 3;
    fr = 0;
    exp_lk = 1'b0;
    repeat (5) begin
      @(negedge Clk);
      apply(1'b1);
    end
    while (fr < 11) begin
      @(negedge Clk);
      apply(at(8, 10, 6));
      advance();
    end
    repeat (3) @(posedge Clk);
    #2;
    chk("drain", 10'(q.size()), 10'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
